// File: rtl/uart_tx_fifo_if.sv
// Byte handshake between a producer and the UART transmit queue.
// Producer drives data/valid; the queue answers with ready.
interface uart_tx_fifo_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small byte FIFO.
// Frames run back to back while the queue holds data.
module uart_tx_fifo #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 9600,
  parameter int DEPTH    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  uart_tx_fifo_if.slave          s,
  output logic                   tx,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int AW  = $clog2(DEPTH);
  localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
  localparam logic [BW-1:0] LAST = BW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE, START, DATA, STOP
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [7:0]      shift;
  logic [2:0]      bit_cnt;
  logic [BW-1:0]   baud_cnt;
  logic            push;
  logic            pop;
  logic            has_data;
  logic            baud_done;
  logic            tx_d;

  // ready comes from the registered count only
  assign s.tx_ready = (fifo_count != FULL);
  assign push       = s.tx_valid && s.tx_ready;
  assign has_data   = |fifo_count;
  assign baud_done  = (baud_cnt == LAST);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (push)
      mem[wptr] <= s.tx_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      overflow <= s.tx_valid && !s.tx_ready;
      if (push)
        wptr <= wptr + 1'b1;
      if (pop)
        rptr <= rptr + 1'b1;
      if (push && !pop)
        fifo_count <= fifo_count + 1'b1;
      else if (pop && !push)
        fifo_count <= fifo_count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:
        if (has_data)
          state_n = START;
      START:
        if (baud_done)
          state_n = DATA;
      DATA:
        if (baud_done && bit_cnt == 3'd7)
          state_n = STOP;
      STOP:
        if (baud_done)
          state_n = has_data ? START : IDLE;
      default:
        state_n = IDLE;
    endcase
  end

  always_comb begin
    pop  = 1'b0;
    tx_d = 1'b1;
    unique case (state)
      IDLE:  pop  = has_data;
      START: tx_d = 1'b0;
      DATA:  tx_d = shift[0];
      STOP:  pop  = baud_done && has_data;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx       <= 1'b1;
      shift    <= '0;
      bit_cnt  <= '0;
      baud_cnt <= '0;
    end else begin
      tx <= tx_d;
      if (pop) begin
        shift    <= mem[rptr];
        bit_cnt  <= '0;
        baud_cnt <= '0;
      end else if (state != IDLE) begin
        baud_cnt <= baud_done ? '0 : baud_cnt + 1'b1;
        if (state == DATA && baud_done) begin
          shift   <= {1'b0, shift[7:1]};
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

endmodule
